// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 CBC controller.
// The iterative core clears its ready flags one cycle after a request; the guard covers that gap.
package aes128_pkg;

   localparam int AES_BLK_W = 128;
   localparam int GUARD_W   = 2;
   localparam logic [GUARD_W-1:0] CORE_GUARD = GUARD_W'(2);

   typedef logic [AES_BLK_W-1:0] blk_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEY_REQ,
      ST_KEY_WAIT,
      ST_READY,
      ST_LOAD,
      ST_BUSY,
      ST_OUT
   } cbc_state_e;

endpackage

// File: rtl/cbc_chain.sv
// CBC chaining datapath: pre-XOR into the core, post-XOR out of it,
// and the next value of the chaining register.
module cbc_chain
   import aes128_pkg::*;
(
   input  logic enc_i,
   input  blk_t blk_i,
   input  blk_t chain_i,
   input  blk_t cin_i,
   input  blk_t iv_i,
   input  blk_t core_out_i,
   input  logic ld_iv_i,
   input  logic upd_i,
   output blk_t core_in_o,
   output blk_t result_o,
   output blk_t chain_o
);

   // Encrypt XORs before the core, decrypt XORs after it.
   assign core_in_o = enc_i ? (blk_i ^ chain_i) : blk_i;
   assign result_o  = enc_i ? core_out_i : (core_out_i ^ chain_i);

   always_comb begin
      chain_o = chain_i;
      if (ld_iv_i) begin
         chain_o = iv_i;
      end else if (upd_i) begin
         // Next chaining value is always the ciphertext of this block.
         chain_o = enc_i ? core_out_i : cin_i;
      end
   end

endmodule

// File: rtl/aes128_cbc_ctrl.sv
// CBC-mode sequencer driving one iterative aes128 core through its
// key-reset / load / ready handshake, with valid/ready block streams.
module aes128_cbc_ctrl
   import aes128_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [AES_BLK_W-1:0] key_i,
   input  logic [AES_BLK_W-1:0] iv_i,
   input  logic                 enc_or_dec_i,
   output logic                 cfg_done_o,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [AES_BLK_W-1:0] in_data_i,
   input  logic                 in_last_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [AES_BLK_W-1:0] out_data_o,
   output logic                 out_last_o,
   output logic                 core_reset_key_o,
   output logic [AES_BLK_W-1:0] core_key_o,
   output logic                 core_load_data_o,
   output logic [AES_BLK_W-1:0] core_data_o,
   output logic                 core_enc_or_dec_o,
   input  logic [AES_BLK_W-1:0] core_data_i,
   input  logic                 core_key_ready_i,
   input  logic                 core_ready_i
);

   cbc_state_e         state_q, state_d;
   blk_t               key_q, key_d;
   blk_t               iv_q, iv_d;
   logic               mode_q, mode_d;
   blk_t               chain_q, chain_d;
   blk_t               cin_q, cin_d;
   logic               last_q, last_d;
   blk_t               out_q, out_d;
   blk_t               cdata_q, cdata_d;
   logic               cfg_done_q, cfg_done_d;
   logic [GUARD_W-1:0] guard_q, guard_d;

   logic chain_ld_iv, chain_upd;
   blk_t core_in, result;

   cbc_chain u_chain (
      .enc_i      (mode_q),
      .blk_i      (in_data_i),
      .chain_i    (chain_q),
      .cin_i      (cin_q),
      .iv_i       (iv_q),
      .core_out_i (core_data_i),
      .ld_iv_i    (chain_ld_iv),
      .upd_i      (chain_upd),
      .core_in_o  (core_in),
      .result_o   (result),
      .chain_o    (chain_d)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         key_q      <= '0;
         iv_q       <= '0;
         mode_q     <= 1'b0;
         chain_q    <= '0;
         cin_q      <= '0;
         last_q     <= 1'b0;
         out_q      <= '0;
         cdata_q    <= '0;
         cfg_done_q <= 1'b0;
         guard_q    <= '0;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         iv_q       <= iv_d;
         mode_q     <= mode_d;
         chain_q    <= chain_d;
         cin_q      <= cin_d;
         last_q     <= last_d;
         out_q      <= out_d;
         cdata_q    <= cdata_d;
         cfg_done_q <= cfg_done_d;
         guard_q    <= guard_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      iv_d        = iv_q;
      mode_d      = mode_q;
      cin_d       = cin_q;
      last_d      = last_q;
      out_d       = out_q;
      cdata_d     = cdata_q;
      cfg_done_d  = cfg_done_q;
      guard_d     = guard_q;
      chain_ld_iv = 1'b0;
      chain_upd   = 1'b0;

      if (start_i) begin
         // Abort whatever is in flight and re-key with the new configuration.
         key_d      = key_i;
         iv_d       = iv_i;
         mode_d     = enc_or_dec_i;
         cfg_done_d = 1'b0;
         state_d    = ST_KEY_REQ;
      end else begin
         unique case (state_q)
            ST_IDLE: ;
            ST_KEY_REQ: begin
               guard_d = CORE_GUARD;
               state_d = ST_KEY_WAIT;
            end
            ST_KEY_WAIT: begin
               if (guard_q != '0) begin
                  guard_d = guard_q - GUARD_W'(1);
               end else if (core_key_ready_i) begin
                  cfg_done_d  = 1'b1;
                  chain_ld_iv = 1'b1;
                  state_d     = ST_READY;
               end
            end
            ST_READY: begin
               if (in_valid_i) begin
                  cdata_d = core_in;
                  if (!mode_q) cin_d = in_data_i;
                  last_d  = in_last_i;
                  state_d = ST_LOAD;
               end
            end
            ST_LOAD: begin
               guard_d = CORE_GUARD;
               state_d = ST_BUSY;
            end
            ST_BUSY: begin
               if (guard_q != '0) begin
                  guard_d = guard_q - GUARD_W'(1);
               end else if (core_ready_i) begin
                  out_d     = result;
                  chain_upd = 1'b1;
                  state_d   = ST_OUT;
               end
            end
            ST_OUT: begin
               if (out_ready_i) begin
                  // A finished message restarts chaining from the IV.
                  chain_ld_iv = last_q;
                  state_d     = ST_READY;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign cfg_done_o        = cfg_done_q;
   assign in_ready_o        = (state_q == ST_READY) && !start_i;
   assign out_valid_o       = (state_q == ST_OUT);
   assign out_data_o        = out_q;
   assign out_last_o        = (state_q == ST_OUT) && last_q;
   assign core_reset_key_o  = (state_q == ST_KEY_REQ);
   assign core_load_data_o  = (state_q == ST_LOAD);
   assign core_key_o        = key_q;
   assign core_data_o       = cdata_q;
   assign core_enc_or_dec_o = mode_q;

endmodule

// File: tb/tb_aes128_cbc_ctrl.sv
// Directed bench for aes128_cbc_ctrl with a behavioural stand-in for the aes128 core
// that knows the FIPS-197 vector and keeps stale ready flags high until re-requested.
module tb_aes128_cbc_ctrl;

   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] P2  = 128'h69d5c2eb2e2e624750541d3bbc692ba5;
   localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk_i = 0, rst_ni = 0;
   logic         start_i = 0, enc_or_dec_i = 0;
   logic [127:0] key_i = '0, iv_i = '0, in_data_i = '0;
   logic         in_valid_i = 0, in_last_i = 0, out_ready_i = 0;
   logic         cfg_done_o, in_ready_o, out_valid_o, out_last_o;
   logic [127:0] out_data_o, core_key_o, core_data_o;
   logic         core_reset_key_o, core_load_data_o, core_enc_or_dec_o;
   logic [127:0] core_data_i;
   logic         core_key_ready_i, core_ready_i;

   int errs = 0, nchk = 0;
   int n_rst = 0, n_load = 0, n_outv = 0;

   always #5 clk_i = ~clk_i;

   aes128_cbc_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .key_i(key_i), .iv_i(iv_i),
      .enc_or_dec_i(enc_or_dec_i), .cfg_done_o(cfg_done_o),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_last_o(out_last_o),
      .core_reset_key_o(core_reset_key_o), .core_key_o(core_key_o), .core_load_data_o(core_load_data_o),
      .core_data_o(core_data_o), .core_enc_or_dec_o(core_enc_or_dec_o),
      .core_data_i(core_data_i), .core_key_ready_i(core_key_ready_i), .core_ready_i(core_ready_i)
   );

   // Core stand-in: answers only the known vector, anything else comes back inverted.
   int           kcnt, dcnt;
   logic [127:0] din;
   logic         dmode;
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         core_key_ready_i <= 0; core_ready_i <= 0; core_data_i <= '0;
         kcnt <= 0; dcnt <= 0; din <= '0; dmode <= 0;
      end else begin
         if (core_reset_key_o) begin
            core_key_ready_i <= 0; kcnt <= 6;
         end else if (kcnt != 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) core_key_ready_i <= 1;
         end
         if (core_load_data_o) begin
            core_ready_i <= 0; dcnt <= 10; din <= core_data_o; dmode <= core_enc_or_dec_o;
         end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
               core_ready_i <= 1;
               if (core_key_o == KEY && dmode && din == P1)       core_data_i <= C1;
               else if (core_key_o == KEY && !dmode && din == C1) core_data_i <= P1;
               else                                               core_data_i <= ~din;
            end
         end
      end
   end

   always @(posedge clk_i) begin
      if (core_reset_key_o) n_rst++;
      if (core_load_data_o) n_load++;
      if (out_valid_o)      n_outv++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [127:0] k, input logic [127:0] iv, input logic enc);
      int r0, n;
      r0 = n_rst;
      key_i = k; iv_i = iv; enc_or_dec_i = enc; start_i = 1;
      #1 check("start_blocks_in_ready", in_ready_o, 0);
      @(negedge clk_i); start_i = 0;
      check("cfg_done_drops", cfg_done_o, 0);
      n = 0;
      while (!cfg_done_o && n < 200) begin @(negedge clk_i); n++; end
      check("cfg_done_timeout", (n < 200), 1);
      check("one_key_reset", n_rst - r0, 1);
   endtask

   task automatic send_in(input logic [127:0] d, input logic last);
      int n = 0;
      while (!in_ready_o && n < 200) begin @(negedge clk_i); n++; end
      check("in_ready_timeout", (n < 200), 1);
      in_valid_i = 1; in_data_i = d; in_last_i = last;
      @(negedge clk_i);
      in_valid_i = 0;
      check("load_latency", core_load_data_o, 1);
   endtask

   task automatic get_out(input int stall, output logic [127:0] q, output logic ql);
      int n = 0, l0;
      bit stable = 1, rdy_low = 1;
      while (!out_valid_o && n < 300) begin @(negedge clk_i); n++; end
      check("out_valid_timeout", (n < 300), 1);
      q = out_data_o; ql = out_last_o; l0 = n_load;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk_i);
         if (!out_valid_o || out_data_o !== q || out_last_o !== ql) stable = 0;
         if (in_ready_o) rdy_low = 0;
      end
      if (stall > 0) begin
         check("stall_stable", stable, 1);
         check("stall_in_ready_low", rdy_low, 1);
         check("stall_no_reload", n_load - l0, 0);
      end
      out_ready_i = 1;
      @(negedge clk_i);
      out_ready_i = 0;
   endtask

   logic [127:0] q;
   logic         ql;
   int           v0;

   initial begin
      repeat (3) @(negedge clk_i);
      check("rst_out_valid", out_valid_o, 0);
      check("rst_in_ready", in_ready_o, 0);
      check("rst_cfg_done", cfg_done_o, 0);
      check("rst_core_reset_key", core_reset_key_o, 0);
      check("rst_core_load", core_load_data_o, 0);
      check("rst_out_data", out_data_o, 0);
      check("rst_core_key", core_key_o, 0);
      rst_ni = 1;
      @(negedge clk_i);
      check("idle_in_ready", in_ready_o, 0);

      // Single encrypt block, FIPS-197 vector.
      do_start(KEY, '0, 1);
      check("core_mode_enc", core_enc_or_dec_o, 1);
      send_in(P1, 1); get_out(0, q, ql);
      check("enc1_data", q, C1);
      check("enc1_last", ql, 1);

      // Two-block message: P2 chains to the same core input, so both outputs equal C1.
      send_in(P1, 0); get_out(0, q, ql);
      check("enc2a_data", q, C1);
      check("enc2a_last", ql, 0);
      check("back_to_back_ready", in_ready_o, 1);
      send_in(P2, 1); get_out(0, q, ql);
      check("enc2b_data", q, C1);
      check("enc2b_last", ql, 1);

      // Decrypt the same two ciphertexts.
      do_start(KEY, '0, 0);
      check("core_mode_dec", core_enc_or_dec_o, 0);
      send_in(C1, 0); get_out(0, q, ql);
      check("dec_a_data", q, P1);
      send_in(C1, 1); get_out(0, q, ql);
      check("dec_b_data", q, P2);
      check("dec_b_last", ql, 1);

      // Output stall for 20 cycles.
      do_start(KEY, '0, 1);
      send_in(P1, 1); get_out(20, q, ql);
      check("stall_data", q, C1);

      // Two single-block messages: chain returns to IV between them.
      send_in(P1, 1); get_out(0, q, ql);
      check("msg1_data", q, C1);
      send_in(P1, 1); get_out(0, q, ql);
      check("msg2_data", q, C1);

      // Abort during BUSY.
      send_in(P1, 1);
      repeat (3) @(negedge clk_i);
      v0 = n_outv;
      do_start(KEY, '0, 1);
      repeat (30) @(negedge clk_i);
      check("abort_no_out_valid", n_outv - v0, 0);
      send_in(P1, 1); get_out(0, q, ql);
      check("after_abort_data", q, C1);

      // Reset mid-block: back to idle, nothing re-keyed until a new start.
      send_in(P1, 1);
      @(negedge clk_i);
      rst_ni = 0;
      #1 check("midrst_out_valid", out_valid_o, 0);
      check("midrst_cfg_done", cfg_done_o, 0);
      @(negedge clk_i); rst_ni = 1;
      v0 = n_rst;
      repeat (20) @(negedge clk_i);
      check("midrst_in_ready", in_ready_o, 0);
      check("midrst_no_rekey", n_rst - v0, 0);
      check("midrst_no_out", out_valid_o, 0);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
